// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the bus datapath.
// Drives register enables, bus-source selects, ALU opcode and memory strobes from state and IR.
module control_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        mem_ready,
  output logic [15:0] reg_enable,
  output logic [15:0] reg_select,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        read,
  output logic        write,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic [4:0]  alu_instruction,
  output logic        run,
  output logic        fault,
  output logic [15:0] instr_count
);

  // state | meaning
  // T0    | PC onto bus, load MAR, bump PC
  // T1    | instruction read, waits on mem_ready
  // T2    | MDR into IR
  // T3    | decode; Rb into Y, or retire nop/hlt/unknown
  // T4    | ALU operation into Z
  // T5    | Z to Ra, or Z to MAR for ld/st
  // T6    | ld: data read (waits); st: Ra into MDR
  // T7    | ld: MDR to Ra; st: write (waits)
  // HALT  | stopped until clr
  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  localparam logic [15:0] WAIT_LOAD = (MEM_TIMEOUT == 0) ? 16'd0 : 16'(MEM_TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] wait_cnt;
  logic [15:0] count_q;
  logic        fault_q;
  logic        retire;
  logic        waiting;
  logic        timeout;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_ld, is_ldi, is_st, is_alu_reg, is_alu_imm, is_hlt, is_exec;
  logic [4:0] imm_alu;
  logic       unused_ir;

  assign op = IR_Data[31:27];
  assign ra = IR_Data[26:23];
  assign rb = IR_Data[22:19];
  assign rc = IR_Data[18:15];
  assign unused_ir = ^IR_Data[14:0];

  always_comb begin
    is_ld      = (op == 5'b00000);
    is_ldi     = (op == 5'b00001);
    is_st      = (op == 5'b00010);
    is_alu_reg = (op >= 5'b00011) && (op <= 5'b01011);
    is_alu_imm = (op >= 5'b01100) && (op <= 5'b01110);
    is_hlt     = (op == 5'b11011);
    is_exec    = is_ld | is_ldi | is_st | is_alu_reg | is_alu_imm;
    case (op)
      5'b01101: imm_alu = 5'b00101;
      5'b01110: imm_alu = 5'b00110;
      default:  imm_alu = 5'b00011;
    endcase
  end

  // Only the three memory-access states count toward the timeout.
  assign waiting = (state == T1) || ((state == T6) && is_ld) || ((state == T7) && is_st);
  assign timeout = (MEM_TIMEOUT != 0) && waiting && !mem_ready && (wait_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (clr) state <= T0;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      fault_q  <= 1'b0;
      count_q  <= 16'd0;
      wait_cnt <= WAIT_LOAD;
    end else begin
      if (timeout) fault_q <= 1'b1;
      if (retire)  count_q <= count_q + 16'd1;
      if (waiting && !mem_ready) wait_cnt <= wait_cnt - 16'd1;
      else                       wait_cnt <= WAIT_LOAD;
    end
  end

  always_comb begin
    state_next          = state;
    retire              = 1'b0;
    reg_enable          = 16'd0;
    reg_select          = 16'd0;
    PC_enable           = 1'b0;
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    read                = 1'b0;
    write               = 1'b0;
    PC_select           = 1'b0;
    Z_LO_select         = 1'b0;
    MDR_select          = 1'b0;
    c_select            = 1'b0;
    alu_instruction     = 5'd0;
    if (!clr) begin
      case (state)
        T0: begin
          PC_select           = 1'b1;
          MAR_enable          = 1'b1;
          PC_increment_enable = 1'b1;
          state_next          = T1;
        end
        T1: begin
          read       = 1'b1;
          MDR_enable = 1'b1;
          if (mem_ready)    state_next = T2;
          else if (timeout) state_next = HALT;
        end
        T2: begin
          MDR_select = 1'b1;
          IR_enable  = 1'b1;
          state_next = T3;
        end
        T3: begin
          if (is_exec) begin
            reg_select = 16'd1 << rb;
            Y_enable   = 1'b1;
            state_next = T4;
          end else begin
            retire     = 1'b1;
            state_next = is_hlt ? HALT : T0;
          end
        end
        T4: begin
          Z_enable = 1'b1;
          if (is_alu_reg) begin
            reg_select      = 16'd1 << rc;
            alu_instruction = op;
          end else begin
            c_select        = 1'b1;
            alu_instruction = imm_alu;
          end
          state_next = T5;
        end
        T5: begin
          Z_LO_select = 1'b1;
          if (is_ld || is_st) begin
            MAR_enable = 1'b1;
            state_next = T6;
          end else begin
            reg_enable = 16'd1 << ra;
            retire     = 1'b1;
            state_next = T0;
          end
        end
        T6: begin
          MDR_enable = 1'b1;
          if (is_ld) begin
            read = 1'b1;
            if (mem_ready)    state_next = T7;
            else if (timeout) state_next = HALT;
          end else begin
            reg_select = 16'd1 << ra;
            state_next = T7;
          end
        end
        T7: begin
          if (is_ld) begin
            MDR_select = 1'b1;
            reg_enable = 16'd1 << ra;
            retire     = 1'b1;
            state_next = T0;
          end else begin
            write = 1'b1;
            if (mem_ready) begin
              retire     = 1'b1;
              state_next = T0;
            end else if (timeout) begin
              state_next = HALT;
            end
          end
        end
        HALT:    state_next = HALT;
        default: state_next = T0;
      endcase
    end
  end

  assign run         = !clr && (state != HALT);
  assign fault       = fault_q && !clr;
  assign instr_count = clr ? 16'd0 : count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer: the driver queues the expected control word
// for every cycle it drives, and a monitor pops and compares each cycle at the falling edge.
module tb_control_sequencer;

  localparam logic [12:0] PCI = 13'h0800, IRE = 13'h0400, YE = 13'h0200, ZE = 13'h0100;
  localparam logic [12:0] MARE = 13'h0080, MDRE = 13'h0040, RD = 13'h0020, WR = 13'h0010;
  localparam logic [12:0] PCS = 13'h0008, ZLS = 13'h0004, MDRS = 13'h0002, CS = 13'h0001;

  localparam logic [31:0] ADD  = 32'h1989_0000; // add  r3,r1,r2
  localparam logic [31:0] SUB  = 32'h5FF6_8000; // op 01011 r15,r14,r13
  localparam logic [31:0] LD   = 32'h0108_0065; // ld   r2,0x65(r1)
  localparam logic [31:0] ORI  = 32'h72A0_0003; // ori  r5,r4,3
  localparam logic [31:0] ANDI = 32'h68C8_0007; // andi r1,r9,7
  localparam logic [31:0] LDI  = 32'h0B80_0010; // ldi  r7,0x10(r0)
  localparam logic [31:0] ST   = 32'h1310_0020; // st   r6,0x20(r2)
  localparam logic [31:0] NOP  = 32'hD000_0000;
  localparam logic [31:0] BAD  = 32'h7800_0000; // op 01111, unassigned
  localparam logic [31:0] HLT  = 32'hD800_0000;

  logic        clk;
  logic        clr;
  logic [31:0] IR_Data;
  logic        mem_ready;
  logic [15:0] reg_enable, reg_select, instr_count;
  logic        PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic        MAR_enable, MDR_enable, read, write;
  logic        PC_select, Z_LO_select, MDR_select, c_select;
  logic [4:0]  alu_instruction;
  logic        run, fault;

  control_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .clr(clr), .IR_Data(IR_Data), .mem_ready(mem_ready),
    .reg_enable(reg_enable), .reg_select(reg_select),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
    .read(read), .write(write),
    .PC_select(PC_select), .Z_LO_select(Z_LO_select),
    .MDR_select(MDR_select), .c_select(c_select),
    .alu_instruction(alu_instruction), .run(run), .fault(fault),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          full;
    logic [67:0] v;
    string       name;
  } exp_t;

  exp_t        q[$];
  logic [67:0] act;
  logic [15:0] exp_cnt;
  logic        exp_flt;
  logic [31:0] ir_pend;
  bit          ir_load;
  bit          stim_done;
  int          errors;
  int          checks;

  assign act = {reg_enable, reg_select, PC_enable, PC_increment_enable, IR_enable, Y_enable,
                Z_enable, MAR_enable, MDR_enable, read, write, PC_select, Z_LO_select,
                MDR_select, c_select, alu_instruction, run, fault, instr_count};

  task automatic cyc(input logic c, input logic mr, input logic [15:0] re, input logic [15:0] rs,
                     input logic [12:0] st, input logic [4:0] alu, input logic r, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    clr = c;
    mem_ready = mr;
    if (ir_load) begin
      IR_Data = ir_pend;
      ir_load = 1'b0;
    end
    e.full = 1'b1;
    e.name = nm;
    e.v    = {re, rs, st, alu, r, c ? 1'b0 : exp_flt, c ? 16'h0 : exp_cnt};
    q.push_back(e);
  endtask

  task automatic rcyc(input logic c, input logic mr, input logic [31:0] ir);
    exp_t e;
    @(posedge clk);
    #1;
    clr = c;
    mem_ready = mr;
    IR_Data = ir;
    e.full = 1'b0;
    e.name = "rand";
    e.v    = '0;
    q.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] ir, input int t1_waits, input string nm);
    ir_pend = ir;
    ir_load = 1'b1;
    cyc(0, 1, 0, 0, PCS | MARE | PCI, 0, 1, {nm, ".t0"});
    for (int i = 0; i < t1_waits; i++) cyc(0, 0, 0, 0, RD | MDRE, 0, 1, {nm, ".t1w"});
    cyc(0, 1, 0, 0, RD | MDRE, 0, 1, {nm, ".t1"});
    cyc(0, 1, 0, 0, MDRS | IRE, 0, 1, {nm, ".t2"});
  endtask

  task automatic halt_cycles(input int n, input logic mr, input string nm);
    for (int i = 0; i < n; i++) cyc(0, mr, 0, 0, 0, 0, 0, nm);
  endtask

  // Monitor: compares each queued expectation and checks the bus invariants every cycle.
  initial begin
    exp_t e;
    int   guard;
    guard  = 0;
    errors = 0;
    checks = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.full) begin
          checks++;
          if (act !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.v);
          end
        end
        checks++;
        if ($countones({reg_select, PC_select, Z_LO_select, MDR_select, c_select}) > 1) begin
          errors++;
          $display("FAIL %s bus_select_onehot: got sel=%h pc=%b zlo=%b mdr=%b c=%b, at most one high",
                   e.name, reg_select, PC_select, Z_LO_select, MDR_select, c_select);
        end
        checks++;
        if ($countones(reg_enable) > 1) begin
          errors++;
          $display("FAIL %s reg_enable_onehot: got %h, at most one bit high", e.name, reg_enable);
        end
        checks++;
        if (read && write) begin
          errors++;
          $display("FAIL %s rd_wr_exclusive: got read=%b write=%b, not both", e.name, read, write);
        end
      end else if (stim_done) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      if (guard > 20000) begin
        checks++;
        errors++;
        $display("FAIL watchdog: got %0d cycles, limit 20000", guard);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin
    clr       = 1'b1;
    mem_ready = 1'b0;
    IR_Data   = 32'h0;
    exp_cnt   = 16'd0;
    exp_flt   = 1'b0;
    ir_pend   = 32'h0;
    ir_load   = 1'b0;
    stim_done = 1'b0;

    cyc(1, 0, 0, 0, 0, 0, 0, "reset");

    // add cut short by clr in T4
    fetch(ADD, 0, "add_cut");
    cyc(0, 1, 0, 16'h0002, YE, 0, 1, "add_cut.t3");
    cyc(1, 1, 0, 0, 0, 0, 0, "add_cut.clr_t4");

    fetch(ADD, 0, "add");
    cyc(0, 1, 0, 16'h0002, YE, 0, 1, "add.t3");
    cyc(0, 1, 0, 16'h0004, ZE, 5'b00011, 1, "add.t4");
    cyc(0, 1, 16'h0008, 0, ZLS, 0, 1, "add.t5");
    exp_cnt = 16'd1;

    fetch(LD, 0, "ld");
    cyc(0, 1, 0, 16'h0002, YE, 0, 1, "ld.t3");
    cyc(0, 1, 0, 0, CS | ZE, 5'b00011, 1, "ld.t4");
    cyc(0, 1, 0, 0, ZLS | MARE, 0, 1, "ld.t5");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, RD | MDRE, 0, 1, "ld.t6w");
    cyc(0, 1, 0, 0, RD | MDRE, 0, 1, "ld.t6");
    cyc(0, 1, 16'h0004, 0, MDRS, 0, 1, "ld.t7");
    exp_cnt = 16'd2;

    fetch(ORI, 0, "ori");
    cyc(0, 1, 0, 16'h0010, YE, 0, 1, "ori.t3");
    cyc(0, 1, 0, 0, CS | ZE, 5'b00110, 1, "ori.t4");
    cyc(0, 1, 16'h0020, 0, ZLS, 0, 1, "ori.t5");
    exp_cnt = 16'd3;

    fetch(LDI, 0, "ldi");
    cyc(0, 1, 0, 16'h0001, YE, 0, 1, "ldi.t3");
    cyc(0, 1, 0, 0, CS | ZE, 5'b00011, 1, "ldi.t4");
    cyc(0, 1, 16'h0080, 0, ZLS, 0, 1, "ldi.t5");
    exp_cnt = 16'd4;

    fetch(ST, 0, "st");
    cyc(0, 1, 0, 16'h0004, YE, 0, 1, "st.t3");
    cyc(0, 1, 0, 0, CS | ZE, 5'b00011, 1, "st.t4");
    cyc(0, 1, 0, 0, ZLS | MARE, 0, 1, "st.t5");
    cyc(0, 0, 0, 16'h0040, MDRE, 0, 1, "st.t6");
    cyc(0, 1, 0, 0, WR, 0, 1, "st.t7");
    exp_cnt = 16'd5;

    fetch(NOP, 0, "nop");
    cyc(0, 1, 0, 0, 0, 0, 1, "nop.t3");
    exp_cnt = 16'd6;

    fetch(BAD, 0, "bad");
    cyc(0, 1, 0, 0, 0, 0, 1, "bad.t3");
    exp_cnt = 16'd7;

    fetch(ANDI, 2, "andi");
    cyc(0, 1, 0, 16'h0200, YE, 0, 1, "andi.t3");
    cyc(0, 1, 0, 0, CS | ZE, 5'b00101, 1, "andi.t4");
    cyc(0, 1, 16'h0002, 0, ZLS, 0, 1, "andi.t5");
    exp_cnt = 16'd8;

    fetch(SUB, 0, "sub");
    cyc(0, 1, 0, 16'h4000, YE, 0, 1, "sub.t3");
    cyc(0, 1, 0, 16'h2000, ZE, 5'b01011, 1, "sub.t4");
    cyc(0, 1, 16'h8000, 0, ZLS, 0, 1, "sub.t5");
    exp_cnt = 16'd9;

    // store whose write never completes: 15 wait cycles then HALT with fault
    fetch(ST, 0, "st_to");
    cyc(0, 1, 0, 16'h0004, YE, 0, 1, "st_to.t3");
    cyc(0, 1, 0, 0, CS | ZE, 5'b00011, 1, "st_to.t4");
    cyc(0, 1, 0, 0, ZLS | MARE, 0, 1, "st_to.t5");
    cyc(0, 1, 0, 16'h0040, MDRE, 0, 1, "st_to.t6");
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, WR, 0, 1, "st_to.t7w");
    exp_flt = 1'b1;
    halt_cycles(5, 0, "st_to.halt");
    halt_cycles(3, 1, "st_to.halt_ready");

    cyc(1, 1, 0, 0, 0, 0, 0, "clr_after_fault");
    exp_flt = 1'b0;
    exp_cnt = 16'd0;

    // three instructions then hlt
    fetch(ADD, 0, "h_add");
    cyc(0, 1, 0, 16'h0002, YE, 0, 1, "h_add.t3");
    cyc(0, 1, 0, 16'h0004, ZE, 5'b00011, 1, "h_add.t4");
    cyc(0, 1, 16'h0008, 0, ZLS, 0, 1, "h_add.t5");
    exp_cnt = 16'd1;
    fetch(LDI, 0, "h_ldi");
    cyc(0, 1, 0, 16'h0001, YE, 0, 1, "h_ldi.t3");
    cyc(0, 1, 0, 0, CS | ZE, 5'b00011, 1, "h_ldi.t4");
    cyc(0, 1, 16'h0080, 0, ZLS, 0, 1, "h_ldi.t5");
    exp_cnt = 16'd2;
    fetch(NOP, 0, "h_nop");
    cyc(0, 1, 0, 0, 0, 0, 1, "h_nop.t3");
    exp_cnt = 16'd3;
    fetch(HLT, 0, "hlt");
    cyc(0, 1, 0, 0, 0, 0, 1, "hlt.t3");
    exp_cnt = 16'd4;
    halt_cycles(100, 1, "hlt.hold");

    cyc(1, 1, 0, 0, 0, 0, 0, "clr_after_hlt");
    exp_cnt = 16'd0;
    fetch(NOP, 0, "restart");
    cyc(0, 1, 0, 0, 0, 0, 1, "restart.t3");
    exp_cnt = 16'd1;

    for (int i = 0; i < 400; i++)
      rcyc((i % 60) == 59, $urandom_range(0, 3) != 0, $urandom());

    stim_done = 1'b1;
  end

endmodule
